// File: rtl/fl_ckpt_ctrl.sv
// Branch checkpoint ring for the rename free list: saves the free-list tail per
// in-flight branch and issues a registered rollback request on a mispredict.
module fl_ckpt_ctrl #(
    parameter int NUM_CKPT = 4,
    parameter int FL_IDX_W = 5,
    parameter int TAG_W    = $clog2(NUM_CKPT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dispatch_en,
    input  logic                branch_dispatch,
    input  logic [FL_IDX_W-1:0] fl_tail_next,
    input  logic                resolve_en,
    input  logic [TAG_W-1:0]    resolve_tag,
    input  logic                mispredict,
    output logic                ckpt_valid,
    output logic [TAG_W-1:0]    ckpt_tag,
    output logic                rollback_en,
    output logic [FL_IDX_W-1:0] FL_rollback_idx,
    output logic [NUM_CKPT-1:0] squash_mask
);
    localparam int CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_CKPT);

    logic [NUM_CKPT-1:0]               valid_q, valid_d;
    logic [NUM_CKPT-1:0][FL_IDX_W-1:0] saved_q, saved_d;
    logic [TAG_W-1:0]                  head_q, head_d;
    logic [TAG_W-1:0]                  tail_q, tail_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic                              rollback_en_q, rollback_en_d;
    logic [FL_IDX_W-1:0]               fl_rollback_idx_q, fl_rollback_idx_d;
    logic [NUM_CKPT-1:0]               squash_mask_q, squash_mask_d;

    logic                hit_s, mispredict_s, correct_s;
    logic                alloc_s, pop_s, ckpt_valid_s;
    logic [TAG_W-1:0]    span_s, occ_s, offset_s;
    logic [CNT_W-1:0]    squash_len_s, mp_count_s;
    logic [NUM_CKPT-1:0] mask_s;

    // Decode this cycle's resolve/allocate/pop events and the squash range.
    always_comb begin
        hit_s        = resolve_en && valid_q[resolve_tag];
        mispredict_s = hit_s && mispredict;
        correct_s    = hit_s && !mispredict;
        ckpt_valid_s = (count_q < FULL_CNT) && !rollback_en_q && !mispredict_s;
        alloc_s      = dispatch_en && branch_dispatch && ckpt_valid_s;
        pop_s        = (count_q != {CNT_W{1'b0}}) && !valid_q[head_q];

        // A live tag equal to tail only happens when the ring is full.
        span_s       = tail_q - resolve_tag;
        squash_len_s = (span_s == {TAG_W{1'b0}}) ? FULL_CNT : {1'b0, span_s};
        mask_s       = {NUM_CKPT{1'b0}};
        offset_s     = {TAG_W{1'b0}};
        for (int i = 0; i < NUM_CKPT; i++) begin
            offset_s  = TAG_W'(i) - resolve_tag;
            mask_s[i] = ({1'b0, offset_s} < squash_len_s);
        end

        occ_s      = resolve_tag - head_q;
        mp_count_s = {1'b0, occ_s} - CNT_W'(pop_s && (head_q != resolve_tag));
    end

    // Next-state computation for the ring and the rollback outputs.
    always_comb begin
        valid_d           = valid_q;
        saved_d           = saved_q;
        head_d            = head_q;
        tail_d            = tail_q;
        count_d           = count_q;
        rollback_en_d     = 1'b0;
        squash_mask_d     = {NUM_CKPT{1'b0}};
        fl_rollback_idx_d = fl_rollback_idx_q;

        if (pop_s) begin
            head_d = head_q + TAG_W'(1);
        end else begin
            head_d = head_q;
        end

        if (mispredict_s) begin
            valid_d           = valid_q & ~mask_s;
            tail_d            = resolve_tag;
            count_d           = mp_count_s;
            rollback_en_d     = 1'b1;
            squash_mask_d     = mask_s;
            fl_rollback_idx_d = saved_q[resolve_tag];
        end else begin
            if (correct_s) begin
                valid_d[resolve_tag] = 1'b0;
            end else begin
                valid_d[resolve_tag] = valid_q[resolve_tag];
            end
            if (alloc_s) begin
                valid_d[tail_q] = 1'b1;
                saved_d[tail_q] = fl_tail_next;
                tail_d          = tail_q + TAG_W'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + CNT_W'(alloc_s) - CNT_W'(pop_s);
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q           <= {NUM_CKPT{1'b0}};
            saved_q           <= '0;
            head_q            <= {TAG_W{1'b0}};
            tail_q            <= {TAG_W{1'b0}};
            count_q           <= {CNT_W{1'b0}};
            rollback_en_q     <= 1'b0;
            fl_rollback_idx_q <= {FL_IDX_W{1'b0}};
            squash_mask_q     <= {NUM_CKPT{1'b0}};
        end else begin
            valid_q           <= valid_d;
            saved_q           <= saved_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            rollback_en_q     <= rollback_en_d;
            fl_rollback_idx_q <= fl_rollback_idx_d;
            squash_mask_q     <= squash_mask_d;
        end
    end

    assign ckpt_valid      = ckpt_valid_s;
    assign ckpt_tag        = tail_q;
    assign rollback_en     = rollback_en_q;
    assign FL_rollback_idx = fl_rollback_idx_q;
    assign squash_mask     = squash_mask_q;

endmodule
